add_seq_ctrl: RTL and testbench

Multi-precision add/subtract sequencer that time-shares a single 16-bit ripple-carry adder slice (the team's `adder16`, instantiated once inside this block) to produce 16·WORDS-bit results. Operands are accepted over a valid/ready handshake and processed one 16-bit slice per clock, least-significant first, with the inter-slice carry held in a register. The result is presented over a second valid/ready handshake. The block sits between the ALU operand registers and the writeback path wherever wide arithmetic is needed without replicating adders.

---
 rtl/add_seq_ctrl_if.sv | 28 ++
 rtl/add_seq_ctrl.sv | 98 +++++++++
 tb/tb_add_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/add_seq_ctrl_if.sv
// Operand/result handshake bundle for the multi-precision add/subtract sequencer.
// The master side issues operands and consumes results; the slave side is the sequencer.
interface add_seq_ctrl_if #(
    parameter int WORDS = 4
);
    localparam int W = 16 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    modport master (
        output in_valid, sub, a, b, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, sub, a, b, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/add_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one shared 16-bit ripple adder walks the
// operand LS slice first, carrying between slices through a register.
module adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic cy;

    always_comb begin
        s  = '0;
        cy = cin;
        for (int i = 0; i < 16; i++) begin
            s[i] = a[i] ^ b[i] ^ cy;
            cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        cout = cy;
    end
endmodule

module add_seq_ctrl #(
    parameter int WORDS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    add_seq_ctrl_if.slave   bus
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [WORDS-1:0][15:0]  a_q, b_q, sum_q;
    logic [IW-1:0]           idx_q;
    logic                    cy_q, ovf_q;
    logic [15:0]             sl_s;
    logic                    sl_c;
    logic                    accept, last;

    assign accept = (state_q == IDLE) && bus.in_valid;
    assign last   = (state_q == RUN) && (idx_q == IW'(WORDS - 1));

    adder16 u_add (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (cy_q),
        .s    (sl_s),
        .cout (sl_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (last)          state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Subtract is a + ~b + 1: invert b at capture and seed the carry with sub.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            idx_q <= '0;
            cy_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.sub ? ~bus.b : bus.b;
            cy_q  <= bus.sub;
            idx_q <= '0;
        end else if (state_q == RUN) begin
            sum_q[idx_q] <= sl_s;
            cy_q         <= sl_c;
            idx_q        <= last ? '0 : idx_q + 1'b1;
            if (last)
                ovf_q <= (a_q[WORDS-1][15] == b_q[WORDS-1][15]) &&
                         (sl_s[15] != a_q[WORDS-1][15]);
        end
    end

    // Gating with rst_n keeps in_ready low for the whole reset pulse.
    assign bus.in_ready  = rst_n && (state_q == IDLE);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.sum       = sum_q;
    assign bus.carry_out = cy_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed and randomized checks of add_seq_ctrl (WORDS=4) against a wide-arithmetic model.
module tb_add_seq_ctrl;
    localparam int WORDS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   rnd_on = 1'b0;

    add_seq_ctrl_if #(.WORDS(WORDS)) bus ();

    add_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference model: one outstanding op, result computed with plain 65-bit arithmetic.
    bit          pending = 1'b0;
    int          cyc = 0;
    int          acc_n = 0;
    logic [63:0] e_sum;
    logic        e_c, e_o;

    always @(negedge clk) begin
        logic [64:0] full;
        logic [63:0] bp;
        logic        exp_v;
        cyc++;
        if (!rst_n) begin
            pending = 1'b0;
            chk("rst in_ready", bus.in_ready, 0);
            chk("rst out_valid", bus.out_valid, 0);
            chk("rst sum", bus.sum, 0);
            chk("rst carry", bus.carry_out, 0);
            chk("rst ovf", bus.overflow, 0);
        end else begin
            exp_v = pending && (cyc >= acc_n + WORDS + 1);
            chk("in_ready", bus.in_ready, !pending);
            chk("out_valid", bus.out_valid, exp_v);
            if (exp_v && bus.out_valid) begin
                chk("model sum", bus.sum, e_sum);
                chk("model carry", bus.carry_out, e_c);
                chk("model ovf", bus.overflow, e_o);
            end
            if (bus.in_valid && bus.in_ready) begin
                bp    = bus.sub ? ~bus.b : bus.b;
                full  = {1'b0, bus.a} + {1'b0, bp} + 65'(bus.sub);
                e_sum = full[63:0];
                e_c   = full[64];
                e_o   = (bus.a[63] == bp[63]) && (full[63] != bus.a[63]);
                pending = 1'b1;
                acc_n   = cyc;
            end else if (exp_v && bus.out_valid && bus.out_ready) begin
                pending = 1'b0;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_on) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL in_ready timeout: got 0 expected 1");
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s);
        wait_ready();
        bus.a = a;
        bus.b = b;
        bus.sub = s;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = ~a;                 // post-acceptance changes must not matter
        bus.b = {$urandom, $urandom};
        bus.sub = ~s;
    endtask

    task automatic run_op(input string nm, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic [63:0] es, input logic ec,
                          input logic eo);
        int lat = 0;
        issue(a, b, s);
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(WORDS));
        chk({nm, " sum"}, bus.sum, es);
        chk({nm, " carry"}, bus.carry_out, ec);
        chk({nm, " ovf"}, bus.overflow, eo);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.sub = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", bus.in_ready, 0);
        chk("reset sum", bus.sum, 0);
        rst_n = 1'b1;
        #1;
        chk("post-release in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        run_op("add slice carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
               64'h0000_0000_0001_0000, 1'b0, 1'b0);
        run_op("add wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
        run_op("add ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_op("sub borrow", 64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_op("sub plain", 64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0);
        run_op("sub ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

        // Backpressure: result must hold while stray in_valid pulses are ignored.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        run_op("bp", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
               64'h1234_5678_9ABC_DF00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.a = {$urandom, $urandom};
            @(posedge clk);
            #1;
            chk("bp hold sum", bus.sum, 64'h1234_5678_9ABC_DF00);
            chk("bp hold valid", bus.out_valid, 1);
            chk("bp in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release in_ready", bus.in_ready, 1);
        chk("bp release valid", bus.out_valid, 0);

        // Back-to-back issue with in_valid held high.
        begin
            int prev = -1;
            int nacc = 0;
            bit acc;
            bus.a = 64'h1;
            bus.b = 64'h2;
            bus.sub = 1'b0;
            bus.in_valid = 1'b1;
            for (int t = 0; t < 60 && nacc < 4; t++) begin
                @(negedge clk);
                acc = bus.in_ready;
                if (acc) begin
                    if (prev >= 0) chk("issue interval", 64'(t - prev), 64'(WORDS + 2));
                    prev = t;
                    nacc++;
                end
                @(posedge clk);
                #1;
                if (acc) begin
                    bus.a = {$urandom, $urandom};
                    bus.b = {$urandom, $urandom};
                    bus.sub = $urandom_range(0, 1);
                end
            end
            bus.in_valid = 1'b0;
            chk("b2b count", 64'(nacc), 4);
        end

        // Asynchronous reset after the second slice edge aborts the op.
        wait_ready();
        bus.a = 64'h1111_2222_3333_4444;
        bus.b = 64'h1;
        bus.sub = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun out_valid", bus.out_valid, 0);
        chk("midrun sum", bus.sum, 0);
        chk("midrun in_ready", bus.in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op("post reset", 64'h1234, 64'h1, 1'b0, 64'h1235, 1'b0, 1'b0);

        // Randomized ops with random consumer stalls; checked by the model.
        rnd_on = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: ra = '1;
                1: ra = 64'h8000_0000_0000_0000;
                2: rb = 64'h7FFF_FFFF_FFFF_FFFF;
                default: ;
            endcase
            issue(ra, rb, 1'(($urandom_range(0, 1))));
        end
        rnd_on = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        wait_ready();
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
